// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, default width
// and the quotient reported for a zero divisor.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

endpackage

// File: rtl/iter_div_unit_if.sv
// Request/response bundle between the ALU (master) and the divider (slave).
interface iter_div_unit_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_signed;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output flush, req_valid, req_a, req_b, req_signed, resp_ready,
    input  req_ready, resp_valid, hi, lo
  );

  modport slave (
    input  flush, req_valid, req_a, req_b, req_signed, resp_ready,
    output req_ready, resp_valid, hi, lo
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on {rem,quo}.
// Invariant rem < divisor keeps the shifted remainder below 2*divisor.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH-1:0] shifted_lo;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ge;

  assign shifted_lo = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign {borrow, diff} = {1'b0, shifted_lo} - {1'b0, divisor};
  // The dropped top bit of the shifted remainder alone guarantees trial >= 0.
  assign ge = rem[WIDTH-1] | ~borrow;

  assign rem_nxt = ge ? diff : shifted_lo;
  assign quo_nxt = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/iter_div_unit.sv
// Iterative restoring divider owning HI/LO; WIDTH steps after accept, divide-by-zero done at accept.
// req_ready only in IDLE, resp_valid held until resp_ready or flush; SIGNED_DIV_EN adds signed divide.
module iter_div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst,
  iter_div_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_QUO = {WIDTH{DIV_ZERO_QUO[0]}};

  div_state_t       state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             req_ready_q;
  logic             resp_valid_q;

  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

`ifdef SIGNED_DIV_EN
  logic neg_a;
  logic neg_q;

  assign op_a   = (bus.req_signed && bus.req_a[WIDTH-1]) ? -bus.req_a : bus.req_a;
  assign op_b   = (bus.req_signed && bus.req_b[WIDTH-1]) ? -bus.req_b : bus.req_b;
  assign res_lo = neg_q ? -quo_nxt : quo_nxt;
  assign res_hi = neg_a ? -rem_nxt : rem_nxt;
`else
  logic unused_signed;

  assign unused_signed = bus.req_signed;
  assign op_a   = bus.req_a;
  assign op_b   = bus.req_b;
  assign res_lo = quo_nxt;
  assign res_hi = rem_nxt;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (dvsr),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rem          <= '0;
      quo          <= '0;
      dvsr         <= '0;
      cnt          <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_a        <= 1'b0;
      neg_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && !bus.flush) begin
            req_ready_q <= 1'b0;
            if (bus.req_b == '0) begin
              hi_q         <= bus.req_a;
              lo_q         <= ZERO_QUO;
              resp_valid_q <= 1'b1;
              state        <= DONE;
            end else begin
              rem   <= '0;
              quo   <= op_a;
              dvsr  <= op_b;
              cnt   <= '0;
              state <= BUSY;
`ifdef SIGNED_DIV_EN
              neg_a <= bus.req_signed & bus.req_a[WIDTH-1];
              neg_q <= bus.req_signed & (bus.req_a[WIDTH-1] ^ bus.req_b[WIDTH-1]);
`endif
            end
          end
        end
        BUSY: begin
          if (bus.flush) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              hi_q         <= res_hi;
              lo_q         <= res_lo;
              resp_valid_q <= 1'b1;
              state        <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.flush || bus.resp_ready) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed bench for iter_div_unit: scoreboard of expected HI/LO, latency,
// hold, flush and asynchronous-reset behaviour.
module tb_iter_div_unit;
  import div_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iter_div_unit_if #(.WIDTH(W)) bus ();

  iter_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  res_t sbq[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    res_t r;
    logic use_signed;
`ifdef SIGNED_DIV_EN
    use_signed = sgn;
`else
    use_signed = sgn & 1'b0;
`endif
    if (b == '0) begin
      r.hi = a;
      r.lo = '1;
    end else if (use_signed) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        r.hi = '0;
        r.lo = 32'h8000_0000;
      end else begin
        r.lo = $signed(a) / $signed(b);
        r.hi = $signed(a) % $signed(b);
      end
    end else begin
      r.lo = a / b;
      r.hi = a % b;
    end
    return r;
  endfunction

  // Called at a negedge; returns #1 after the accept edge with operands scrambled.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn, input bit push);
    chk("req_ready_before_issue", {31'd0, bus.req_ready}, 32'd1);
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_signed = sgn;
    bus.req_valid  = 1'b1;
    if (push) sbq.push_back(model(a, b, sgn));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom();
    bus.req_b     = $urandom();
  endtask

  task automatic wait_resp(input string tag, input int exp_edges);
    int   edges;
    res_t e;
    edges = 0;
    @(negedge clk);
    while (!bus.resp_valid && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    chk({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    if (sbq.size() > 0) e = sbq.pop_front();
    else e = 'x;
    chk({tag, "_hi"}, bus.hi, e.hi);
    chk({tag, "_lo"}, bus.lo, e.lo);
  endtask

  task automatic release_resp(input string tag);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk({tag, "_idle_ready"}, {31'd0, bus.req_ready}, 32'd1);
    chk({tag, "_idle_valid"}, {31'd0, bus.resp_valid}, 32'd0);
  endtask

  initial begin
    res_t hold_exp;
    logic seen;

    bus.flush      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_signed = 1'b0;
    bus.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'd100, 32'd7, 1'b0, 1'b1);
    wait_resp("div100_7", 32);
    release_resp("div100_7");

    issue(32'd5, 32'd0, 1'b0, 1'b1);
    wait_resp("div5_0", 0);
    release_resp("div5_0");

    hold_exp = model(32'hFFFF_FFFF, 32'h10, 1'b0);
    issue(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1);
    wait_resp("divmax_16", 32);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("hold_hi", bus.hi, hold_exp.hi);
      chk("hold_lo", bus.lo, hold_exp.lo);
    end
    release_resp("divmax_16");

    issue(32'd9, 32'd4, 1'b0, 1'b1);
    wait_resp("div9_4", 32);
    release_resp("div9_4");
    issue(32'd1000, 32'd3, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      seen |= bus.resp_valid;
    end
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("flush_busy_hi", bus.hi, 32'd1);
    chk("flush_busy_lo", bus.lo, 32'd2);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen |= bus.resp_valid;
    end
    chk("flush_busy_no_resp", {31'd0, seen}, 32'd0);

    bus.req_a     = 32'd8;
    bus.req_b     = 32'd2;
    bus.req_valid = 1'b1;
    bus.flush     = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    @(negedge clk);
    chk("flush_idle_ready", {31'd0, bus.req_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen |= bus.resp_valid;
    end
    chk("flush_idle_no_resp", {31'd0, seen}, 32'd0);

    issue(32'd50, 32'd7, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("arst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    issue(32'd20, 32'd6, 1'b0, 1'b1);
    wait_resp("div20_6", 32);
    release_resp("div20_6");

`ifdef SIGNED_DIV_EN
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    wait_resp("sdiv_m7_2", 32);
    release_resp("sdiv_m7_2");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_resp("sdiv_min_m1", 32);
    release_resp("sdiv_min_m1");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/iter_div_unit.md
Name: iter_div_unit

Overview:
Multi-cycle restoring divider that serves the ALU's divide requests and owns the architectural HI/LO result registers. Replaces the single-cycle combinational divide with a one-bit-per-cycle iterative datapath behind a valid/ready handshake. While a divide is in flight, the pipeline stalls on `req_ready`/`resp_valid`.

Parameters:
- WIDTH, 32, operand/result width in bits (must be ≥2)
- CNT_W, $clog2(WIDTH), iteration counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush; aborts any in-flight divide
- req_valid  in  1  divide request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_a  in  WIDTH  dividend
- req_b  in  WIDTH  divisor
- req_signed  in  1  signed divide; ignored unless SIGNED_DIV_EN is defined
- resp_valid  out  1  result available on hi/lo
- resp_ready  in  1  consumer takes the result
- hi  out  WIDTH  remainder register
- lo  out  WIDTH  quotient register

Behaviour:
- Reset is asynchronous and active-high on rst. Reset state: state=IDLE, hi=0, lo=0, resp_valid=0, req_ready=1, and the counter and working registers are 0.
- Reset asserted mid-operation returns to IDLE immediately. The partial result is discarded.
- States:
  - IDLE: req_ready=1. On a clock edge with req_valid=1 and flush=0, the request is accepted (edge E0).
    - If req_b==0: go to DONE at E0. Load lo = all ones and hi = req_a.
    - Otherwise: go to BUSY. Load rem=0, quo=req_a, divisor=req_b, cnt=0.
  - BUSY: one restoring step per edge.
    - {rem,quo} is shifted left 1.
    - trial = shifted rem − divisor, computed at WIDTH+1 bits.
    - If trial ≥ 0: rem=trial and quo[0]=1; else quo[0]=0.
    - cnt increments each step. The step taken with cnt==WIDTH-1 moves the state to DONE and writes hi=final rem, lo=final quo.
  - DONE: resp_valid=1 and hi/lo are stable. On an edge with resp_ready=1, go to IDLE. resp_valid holds indefinitely while resp_ready=0.
- Latency: steps occur on edges E1..E_WIDTH. resp_valid becomes visible after edge E_WIDTH (32 edges after E0 at default). Divide-by-zero is visible after E0.
- req_ready=0 in BUSY and DONE, so no back-to-back accept from DONE. A new request needs one IDLE cycle.
- hi/lo are written only on entry to DONE and otherwise hold their last value.
- flush=1 in BUSY or DONE: go to IDLE on that edge, hi/lo are unchanged, resp_valid drops.
- flush=1 in IDLE with req_valid=1: flush wins and the request is not accepted.
- flush=1 in DONE with resp_ready=1: go to IDLE. The response is treated as dropped, but hi/lo keep the new values.
- Unsigned arithmetic only (without the macro). Operands are sampled at E0; later changes on req_a/req_b are ignored.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined: when req_signed=1 at accept, the unit stores the sign of a and the XOR of the signs of a and b. It iterates on the magnitudes |a| and |b|.
  - On entry to DONE, lo is negated if the signs differed, and hi takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divide-by-zero gives lo = all ones, hi = req_a.
  - Latency is unchanged.
- Not defined: req_signed is ignored and all divides are unsigned. No sign logic is synthesized.

Decomposition:
- Package div_pkg holds:
  - state encoding (IDLE, BUSY, DONE)
  - DIV_WIDTH default
  - the divide-by-zero quotient constant (all ones)
- Sub-module div_step: a combinational single restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once in the unit.

Test Plan:
- 100 / 7 unsigned → resp_valid 32 edges after accept; lo=14, hi=2. With resp_ready=1, back in IDLE and req_ready=1 one edge later.
- 5 / 0 → resp_valid after the accept edge; lo=0xFFFFFFFF, hi=5.
- 0xFFFFFFFF / 0x10 with resp_ready held 0 for 10 cycles → resp_valid, hi=0xF, lo=0x0FFFFFFF stay stable for all 10 cycles; IDLE one edge after resp_ready=1.
- First 9/4 completes (lo=2, hi=1); then start 1000/3 and assert flush at BUSY cycle 10 → IDLE, hi=1 and lo=2 retained, resp_valid never asserted.
- rst pulsed during BUSY (asynchronous, between edges) → immediate IDLE with hi=lo=0; then 20/6 completes with lo=3, hi=2.
- With SIGNED_DIV_EN:
  - req_signed=1, −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 0x80000000 / −1 → lo=0x80000000, hi=0.
